m_7seg_scan: RTL and testbench

M_7SEG_SCAN -- requirements
Module: m_7seg_scan

---
 rtl/m_7seg_scan.sv | 187 ++++++++++++++++++
 tb/tb_m_7seg_scan.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/m_7seg_scan.sv
// Multiplexed hex display driver for NUM_DIGITS common-anode digits with a per-slot
// ghosting dead clock, leading-zero blanking, decimal points and frame-based blinking.
module m_7seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64
) (
    input  logic                    w_clk,
    input  logic                    w_rst_n,
    input  logic [4*NUM_DIGITS-1:0] w_val,
    input  logic [NUM_DIGITS-1:0]   w_dp,
    input  logic                    w_load,
    input  logic                    w_lzb,
    input  logic                    w_blink,
    output logic [6:0]              r_seg,
    output logic                    r_dp,
    output logic [NUM_DIGITS-1:0]   r_an,
    output logic                    r_busy
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = $clog2(BLINK_DIV + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h58;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]           presc_r;
    logic [IW-1:0]           idx_r;
    logic [FW-1:0]           frame_r;
    logic                    phase_r;
    logic [4*NUM_DIGITS-1:0] shadow_val_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [4*NUM_DIGITS-1:0] disp_val_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;

    logic [PW-1:0]           presc_nxt_s;
    logic [IW-1:0]           idx_nxt_s;
    logic                    slot_end_s;
    logic                    frame_end_s;
    logic [NUM_DIGITS-1:0]   blank_vec_s;
    logic [3:0]              nib_s;
    logic                    dark_s;
    logic [NUM_DIGITS-1:0]   an_nxt_s;
    logic [6:0]              seg_nxt_s;
    logic                    dp_nxt_s;

    // Prescaler and digit index next-state.
    always_comb begin
        slot_end_s  = (presc_r == PRESC_LAST);
        frame_end_s = slot_end_s && (idx_r == IDX_LAST);
        presc_nxt_s = presc_r + PRESC_ONE;
        idx_nxt_s   = idx_r;
        if (slot_end_s) begin
            presc_nxt_s = {PW{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = {IW{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IDX_ONE;
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Leading-zero map: digit i blanks when it and every digit above it are zero.
    always_comb begin
        logic all_zero;
        all_zero    = 1'b1;
        blank_vec_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero       = all_zero & (disp_val_r[4*i +: 4] == 4'h0);
            blank_vec_s[i] = all_zero;
        end
    end

    // Output decode for the current slot; dead clock and blink-off both darken the digit.
    always_comb begin
        nib_s     = disp_val_r[{idx_r, 2'b00} +: 4];
        dark_s    = (presc_r == {PW{1'b0}}) || (w_blink && phase_r);
        an_nxt_s  = {NUM_DIGITS{1'b1}};
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
        if (dark_s) begin
            an_nxt_s  = {NUM_DIGITS{1'b1}};
            seg_nxt_s = 7'h7F;
            dp_nxt_s  = 1'b1;
        end else begin
            an_nxt_s  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r);
            seg_nxt_s = (w_lzb && blank_vec_s[idx_r]) ? 7'h7F : hex_to_seg(nib_s);
            dp_nxt_s  = ~disp_dp_r[idx_r];
        end
    end

    // Scan counters.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else begin
            presc_r <= presc_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Frame counter and blink phase, held cleared while blinking is off.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            frame_r <= {FW{1'b0}};
            phase_r <= 1'b0;
        end else if (!w_blink) begin
            frame_r <= {FW{1'b0}};
            phase_r <= 1'b0;
        end else if (frame_end_s) begin
            if (frame_r == FRAME_LAST) begin
                frame_r <= {FW{1'b0}};
                phase_r <= ~phase_r;
            end else begin
                frame_r <= frame_r + FRAME_ONE;
            end
        end
    end

    // Shadow capture, then transfer to the displayed copy only at slot boundaries,
    // so a load on a boundary edge waits one further slot.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
            disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
        end else begin
            if (w_load) begin
                shadow_val_r <= w_val;
                shadow_dp_r  <= w_dp;
            end
            if (slot_end_s) begin
                disp_val_r <= shadow_val_r;
                disp_dp_r  <= shadow_dp_r;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_an   <= {NUM_DIGITS{1'b1}};
            r_seg  <= 7'h7F;
            r_dp   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_an   <= an_nxt_s;
            r_seg  <= seg_nxt_s;
            r_dp   <= dp_nxt_s;
            r_busy <= w_load;
        end
    end

endmodule

// File: tb/tb_m_7seg_scan.sv
// Scoreboard bench for m_7seg_scan (4 digits, 4 clocks per slot, 2 frames per blink half).
module tb_m_7seg_scan;

    logic        w_clk = 1'b0;
    logic        w_rst_n;
    logic [15:0] w_val;
    logic [3:0]  w_dp;
    logic        w_load;
    logic        w_lzb;
    logic        w_blink;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic [3:0]  r_an;
    logic        r_busy;

    m_7seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_val(w_val), .w_dp(w_dp),
        .w_load(w_load), .w_lzb(w_lzb), .w_blink(w_blink),
        .r_seg(r_seg), .r_dp(r_dp), .r_an(r_an), .r_busy(r_busy)
    );

    always #5 w_clk = ~w_clk;

    // Rising edges seen since the last reset release.
    int cyc;
    always @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct { int cyc; logic [3:0] an; logic [6:0] seg; logic dp; } disp_t;
    typedef struct { int cyc; logic b; } busy_t;
    typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; logic b; } rst_t;

    disp_t disp_q[$];
    busy_t busy_q[$];
    rst_t  rst_q[$];
    event  probe_ev;
    logic  ending = 1'b0;
    int    checks = 0;
    int    errors = 0;

    task automatic push_d(input int c, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        disp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.dp = dp;
        disp_q.push_back(e);
    endtask

    task automatic push_b(input int c, input logic b);
        busy_t e;
        e.cyc = c; e.b = b;
        busy_q.push_back(e);
    endtask

    // One frame starting with digit 0's dead clock at edge 'base'; rdp is r_dp per digit.
    task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] rdp);
        logic [3:0] an_tab [4];
        logic [6:0] s [4];
        an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
        s      = '{s0, s1, s2, s3};
        for (int d = 0; d < 4; d++) begin
            push_d(base + 4*d, 4'hF, 7'h7F, 1'b1);
            for (int k = 1; k < 4; k++) push_d(base + 4*d + k, an_tab[d], s[d], rdp[d]);
        end
    endtask

    task automatic push_blank(input int first, input int n);
        for (int i = 0; i < n; i++) push_d(first + i, 4'hF, 7'h7F, 1'b1);
    endtask

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        do begin
            @(negedge w_clk);
            g++;
            if (g > 2000) begin
                $display("FAIL wait_cyc timeout target=%0d now=%0d", n, cyc);
                $fatal(1, "bench timeout");
            end
        end while (cyc != n);
    endtask

    task automatic probe_reset();
        rst_t e;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.b = 1'b0;
        rst_q.push_back(e);
        -> probe_ev;
    endtask

    // Monitor: compares whatever the scoreboard holds for the current edge.
    initial begin
        disp_t d;
        busy_t b;
        rst_t  r;
        forever begin
            @(negedge w_clk or probe_ev);
            while (rst_q.size() > 0) begin
                r = rst_q.pop_front();
                checks++;
                if (r_an !== r.an || r_seg !== r.seg || r_dp !== r.dp || r_busy !== r.b) begin
                    errors++;
                    $display("FAIL reset_state an=%h seg=%h dp=%b busy=%b want an=%h seg=%h dp=%b busy=%b",
                             r_an, r_seg, r_dp, r_busy, r.an, r.seg, r.dp, r.b);
                end
            end
            while (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
                d = disp_q.pop_front();
                checks++;
                if (d.cyc != cyc) begin
                    errors++;
                    $display("FAIL disp_missed entry=%0d now=%0d", d.cyc, cyc);
                end else if (r_an !== d.an || r_seg !== d.seg || r_dp !== d.dp) begin
                    errors++;
                    $display("FAIL disp@%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                             cyc, r_an, r_seg, r_dp, d.an, d.seg, d.dp);
                end
            end
            while (busy_q.size() > 0 && busy_q[0].cyc <= cyc) begin
                b = busy_q.pop_front();
                checks++;
                if (b.cyc != cyc || r_busy !== b.b) begin
                    errors++;
                    $display("FAIL busy@%0d got=%b want=%b (entry %0d)", cyc, r_busy, b.b, b.cyc);
                end
            end
            if (ending) begin
                checks++;
                if (disp_q.size() != 0 || busy_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover disp=%0d busy=%0d want 0", disp_q.size(), busy_q.size());
                end
            end
        end
    end

    // Stimulus.
    initial begin
        w_rst_n = 1'b1; w_val = 16'h0000; w_dp = 4'h0;
        w_load = 1'b0; w_lzb = 1'b0; w_blink = 1'b0;
        #1 w_rst_n = 1'b0;
        #1 probe_reset();

        push_frame(17,  7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
        push_frame(33,  7'h40, 7'h58, 7'h7F, 7'h7F, 4'hF);
        push_frame(49,  7'h40, 7'h58, 7'h40, 7'h40, 4'hF);
        push_frame(65,  7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);
        push_frame(81,  7'h00, 7'h58, 7'h02, 7'h12, 4'b1011);
        push_frame(97,  7'h00, 7'h58, 7'h02, 7'h12, 4'b1011);
        push_frame(113, 7'h00, 7'h58, 7'h02, 7'h12, 4'b1011);
        push_blank(129, 32);
        push_frame(161, 7'h00, 7'h58, 7'h02, 7'h12, 4'b1011);
        push_frame(177, 7'h00, 7'h58, 7'h02, 7'h12, 4'b1011);
        push_blank(193, 8);
        push_d(201, 4'hF, 7'h7F, 1'b1);
        for (int k = 202; k <= 204; k++) push_d(k, 4'hB, 7'h02, 1'b0);
        push_d(205, 4'hF, 7'h7F, 1'b1);
        for (int k = 206; k <= 208; k++) push_d(k, 4'h7, 7'h12, 1'b1);
        push_b(13, 1'b0); push_b(14, 1'b1); push_b(15, 1'b0);
        push_b(30, 1'b1); push_b(31, 1'b0);
        push_b(62, 1'b1); push_b(63, 1'b0);
        push_b(78, 1'b1); push_b(79, 1'b0);

        @(negedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;

        wait_cyc(13); w_val = 16'h1234; w_dp = 4'h0; w_load = 1'b1;
        wait_cyc(14); w_load = 1'b0;
        wait_cyc(29); w_val = 16'h0070; w_load = 1'b1; w_lzb = 1'b1;
        wait_cyc(30); w_load = 1'b0;
        wait_cyc(48); w_lzb = 1'b0;
        wait_cyc(61); w_val = 16'h0000; w_load = 1'b1;
        wait_cyc(62); w_load = 1'b0;
        wait_cyc(64); w_lzb = 1'b1;
        wait_cyc(77); w_val = 16'h5678; w_dp = 4'b0100; w_load = 1'b1;
        wait_cyc(78); w_load = 1'b0;
        wait_cyc(80); w_lzb = 1'b0;
        wait_cyc(96); w_blink = 1'b1;
        wait_cyc(200); w_blink = 1'b0;

        // Reset in the middle of a lit slot, checked before any clock edge.
        wait_cyc(209);
        @(posedge w_clk);
        #2 w_rst_n = 1'b0;
        #1 probe_reset();
        @(negedge w_clk);
        @(negedge w_clk);
        push_frame(1, 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        w_rst_n = 1'b1;
        wait_cyc(18);
        #1;
        ending = 1'b1;
        -> probe_ev;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
